// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared definitions for the multi-cycle RV64-subset control FSM:
//   state encodings, opcode constants, ALU operation codes and the ALU
//   B-operand select codes. Imported by multicycle_control and by anything
//   that wants to decode the State debug output symbolically.
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

  // State encodings are fixed because State is exported for debug and
  // verification; tools and scripts rely on these exact values.
  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } ctrlState;

  // Supported major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALUOp codes seen by the ALU control block.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select codes.
  localparam logic [1:0] SRCB_RS2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

  // States that hold on the memory handshake and are guarded by the
  // wait/timeout counter.
  function automatic logic isWaitState(input ctrlState s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

  // Dispatch out of DECODE; anything not in the subset is a trap.
  function automatic ctrlState decodeTarget(input logic [6:0] op);
    ctrlState target;
    case (op)
      OP_RTYPE:     target = S_EXEC_R;
      OP_LD, OP_SD: target = S_MEM_ADDR;
      OP_BEQ:       target = S_BRANCH;
      default:      target = S_TRAP;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore-style control FSM for a multi-cycle RV64-subset datapath (R-type,
//   ld, sd, beq) built around one shared ALU, one unified memory and the
//   register file. One instruction takes several cycles; memory accesses wait
//   on MemReady, and a wait that exceeds TIMEOUT_CYCLES traps. Illegal opcodes
//   also trap. TRAP is sticky until Reset.
//
// Parameters
//   TIMEOUT_CYCLES : max consecutive MemReady-low cycles in a wait state
//                    before trapping; 0 disables the timeout.
//   CNT_W          : wait counter width; must be able to hold TIMEOUT_CYCLES.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-high reset, forces INIT
//   OpCode     in   [6:0] opcode from IR, stable from DECODE to next FETCH end
//   Zero       in   ALU zero flag (beq condition)
//   MemReady   in   memory completes the current access this cycle
//   PCWrite    out  PC load enable (beq condition already folded in)
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead    out  memory read request
//   MemWrite   out  memory write request
//   IRWrite    out  IR load enable
//   MemToReg   out  writeback select: 0 = ALUOut, 1 = MDR
//   RegWrite   out  register file write enable
//   ALUSrcA    out  0 = PC, 1 = rs1
//   ALUSrcB    out  [1:0] 00 rs2, 01 const 4, 10 imm, 11 imm<<1
//   ALUOp      out  [1:0] 00 add, 01 sub/compare, 10 funct-decoded
//   PCSource   out  0 = ALU result, 1 = ALUOut (branch target)
//   InstrDone  out  one-cycle pulse on the last cycle of each instruction
//   Error      out  high while in TRAP
//   State      out  [3:0] current state encoding (debug)
//
// Outputs decode combinationally from the state register (plus MemReady or
// Zero in a few states), so an asynchronous Reset removes every request,
// including a pending MemWrite, in the same cycle it asserts.
// -----------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] OpCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic       InstrDone,
  output logic       Error,
  output logic [3:0] State
);

  // Limit widened by one bit so the "count would reach the limit" compare
  // below cannot overflow even when waitCnt is saturated.
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  ctrlState         state;
  ctrlState         stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W:0]   cntInc;
  logic             timeoutHit;

  // ---------------------------------------------------------------------------
  // Timeout detection
  // This cycle is the TIMEOUT_CYCLES-th consecutive MemReady-low cycle in the
  // current wait state. MemReady high always wins over the limit.
  // ---------------------------------------------------------------------------
  assign cntInc     = {1'b0, waitCnt} + (CNT_W+1)'(1);
  assign timeoutHit = TIMEOUT_EN && isWaitState(state) && !MemReady &&
                      (cntInc >= LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path assigned,
    // so no latch is inferred for stateNext or any output below.
    stateNext = state;
    case (state)
      S_INIT:     stateNext = S_FETCH;
      S_FETCH: begin
        if (MemReady)        stateNext = S_DECODE;
        else if (timeoutHit) stateNext = S_TRAP;
      end
      S_DECODE:   stateNext = decodeTarget(OpCode);
      S_EXEC_R:   stateNext = S_R_WB;
      S_R_WB:     stateNext = S_FETCH;
      S_MEM_ADDR: stateNext = (OpCode == OP_LD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (MemReady)        stateNext = S_MEM_WB;
        else if (timeoutHit) stateNext = S_TRAP;
      end
      S_MEM_WB:   stateNext = S_FETCH;
      S_MEM_WRITE: begin
        if (MemReady)        stateNext = S_FETCH;
        else if (timeoutHit) stateNext = S_TRAP;
      end
      S_BRANCH:   stateNext = S_FETCH;
      S_TRAP:     stateNext = S_TRAP;
      // Encodings 11-15 are unreachable in normal operation; treat an
      // upset into them as a fault.
      default:    stateNext = S_TRAP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_INIT;
      waitCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state <= stateNext;
      if (stateNext != state) begin
        waitCnt <= '0;
      end else if (isWaitState(state) && !MemReady && (waitCnt != '1)) begin
        // Saturating: a stuck wait with the timeout disabled must not wrap.
        waitCnt <= waitCnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    PCSource  = 1'b0;
    InstrDone = 1'b0;
    Error     = 1'b0;
    case (state)
      S_FETCH: begin
        // PC + 4 computed in parallel with the instruction read; both the
        // IR and the PC commit only on the cycle memory delivers.
        MemRead = 1'b1;
        IorD    = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        // Speculatively form the branch target PC + (imm<<1) into ALUOut.
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMM_SH1;
        ALUOp   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b0;
        InstrDone = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      S_BRANCH: begin
        // rs1 - rs2 sets Zero; the target already sits in ALUOut.
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        PCSource  = 1'b1;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      S_TRAP: begin
        Error = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control with TIMEOUT_CYCLES = 4. Each task
//   walks one scenario cycle by cycle and compares State and the full packed
//   output vector against hand-derived constants.
//
//   Packed output vector (15 bits, MSB first):
//     PCWrite IorD MemRead MemWrite IRWrite MemToReg RegWrite ALUSrcA
//     ALUSrcB[1:0] ALUOp[1:0] PCSource InstrDone Error
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [6:0] OpCode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite;
  logic       ALUSrcA, PCSource, InstrDone, Error;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] State;

  int nChecks = 0;
  int nErrors = 0;

  logic [14:0] outs;
  assign outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Error};

  // Expected output vectors per state (hand-derived).
  localparam logic [14:0] O_ZERO    = 15'b000000000000000;
  localparam logic [14:0] O_F_RDY   = 15'b101010000100000;
  localparam logic [14:0] O_F_NRDY  = 15'b001000000100000;
  localparam logic [14:0] O_DECODE  = 15'b000000001100000;
  localparam logic [14:0] O_EXEC_R  = 15'b000000010010000;
  localparam logic [14:0] O_R_WB    = 15'b000000100000010;
  localparam logic [14:0] O_MADDR   = 15'b000000011000000;
  localparam logic [14:0] O_MREAD   = 15'b011000000000000;
  localparam logic [14:0] O_MWB     = 15'b000001100000010;
  localparam logic [14:0] O_MW_RDY  = 15'b010100000000010;
  localparam logic [14:0] O_MW_NRDY = 15'b010100000000000;
  localparam logic [14:0] O_BR_Z1   = 15'b100000010001110;
  localparam logic [14:0] O_BR_Z0   = 15'b000000010001110;
  localparam logic [14:0] O_TRAP    = 15'b000000000000001;

  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] SD    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;

  multicycle_control #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (5)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .OpCode   (OpCode),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .InstrDone(InstrDone),
    .Error    (Error),
    .State    (State)
  );

  always #5 Clk = ~Clk;

  // Mutual-exclusion invariants, sampled on the inactive edge.
  always @(negedge Clk) begin
    nChecks++;
    if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
      nErrors++;
      $display("FAIL excl: MemRead=%0b MemWrite=%0b RegWrite=%0b state=%0d",
               MemRead, MemWrite, RegWrite, State);
    end
  end

  // Advance one clock; apply this cycle's inputs just after the edge and let
  // the combinational outputs settle before the caller samples.
  task automatic tick(input logic mr, input logic zr);
    @(posedge Clk);
    #1;
    MemReady = mr;
    Zero     = zr;
    #1;
  endtask

  // Pulse reset between edges; returns at a falling edge with State = INIT.
  task automatic doReset;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    nChecks++;
    if (State !== 4'd0 || outs !== O_ZERO) begin
      nErrors++;
      $display("FAIL reset_async: state=%0d outs=%b expected state=0 outs=%b",
               State, outs, O_ZERO);
    end
    @(posedge Clk);
    #1;
    nChecks++;
    if (State !== 4'd0 || outs !== O_ZERO) begin
      nErrors++;
      $display("FAIL reset_held: state=%0d outs=%b expected state=0 outs=%b",
               State, outs, O_ZERO);
    end
  endtask

  task automatic test_rtype;
    logic [3:0]  expState [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [14:0] expOuts  [5] = '{O_F_RDY, O_DECODE, O_EXEC_R, O_R_WB, O_F_RDY};
    int doneCnt = 0;
    OpCode = RTYPE;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL rtype[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
      if (InstrDone) doneCnt++;
    end
    nChecks++;
    if (doneCnt !== 1) begin
      nErrors++;
      $display("FAIL rtype_done_count: got %0d expected 1", doneCnt);
    end
  endtask

  task automatic test_ld_wait;
    logic        mrSeq    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  expState [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd1};
    logic [14:0] expOuts  [8] = '{O_F_RDY, O_DECODE, O_MADDR, O_MREAD, O_MREAD,
                                  O_MREAD, O_MWB, O_F_RDY};
    OpCode = LD;
    doReset();
    for (int i = 0; i < 8; i++) begin
      tick(mrSeq[i], 1'b0);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL ld[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
    end
  endtask

  task automatic test_sd;
    logic [3:0]  expState [5] = '{4'd1, 4'd2, 4'd5, 4'd8, 4'd1};
    logic [14:0] expOuts  [5] = '{O_F_RDY, O_DECODE, O_MADDR, O_MW_RDY, O_F_RDY};
    int wrCnt  = 0;
    int regCnt = 0;
    OpCode = SD;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL sd[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
      if (MemWrite) wrCnt++;
      if (RegWrite) regCnt++;
    end
    nChecks++;
    if (wrCnt !== 1 || regCnt !== 0) begin
      nErrors++;
      $display("FAIL sd_counts: memwrite=%0d regwrite=%0d expected 1 and 0",
               wrCnt, regCnt);
    end
  endtask

  task automatic test_beq(input logic zr);
    logic [3:0]  expState [4] = '{4'd1, 4'd2, 4'd9, 4'd1};
    logic [14:0] expOuts  [4];
    expOuts = '{O_F_RDY, O_DECODE, (zr ? O_BR_Z1 : O_BR_Z0), O_F_RDY};
    OpCode = BEQ;
    doReset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, zr);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL beq_z%0b[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 zr, i, State, outs, expState[i], expOuts[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [3:0] expState [3] = '{4'd1, 4'd2, 4'd10};
    int badHold = 0;
    OpCode = 7'b1111111;
    doReset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      nChecks++;
      if (State !== expState[i]) begin
        nErrors++;
        $display("FAIL illegal[%0d]: state=%0d expected %0d", i, State, expState[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      if (State !== 4'd10 || outs !== O_TRAP) badHold++;
    end
    nChecks++;
    if (badHold !== 0) begin
      nErrors++;
      $display("FAIL trap_sticky: %0d of 20 cycles left TRAP, expected 0", badHold);
    end
    Reset = 1'b1;
    #1;
    nChecks++;
    if (State !== 4'd0 || Error !== 1'b0) begin
      nErrors++;
      $display("FAIL trap_reset: state=%0d error=%0b expected state=0 error=0",
               State, Error);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_timeout;
    logic [3:0]  expState [5] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd10};
    logic [14:0] expOuts  [5] = '{O_F_NRDY, O_F_NRDY, O_F_NRDY, O_F_NRDY, O_TRAP};
    OpCode = RTYPE;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL timeout[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
    end
  endtask

  task automatic test_timeout_rescue;
    logic        mrSeq    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  expState [5] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    logic [14:0] expOuts  [5] = '{O_F_NRDY, O_F_NRDY, O_F_NRDY, O_F_RDY, O_DECODE};
    OpCode = RTYPE;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick(mrSeq[i], 1'b0);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL rescue[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
    end
  endtask

  // Two waits of 3 cycles in consecutive wait states: only passes if the
  // counter clears on the state change. Then a beq follows without reset.
  task automatic test_back_to_back;
    logic        mrSeq    [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  expState [14] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd5, 4'd8,
                                   4'd8, 4'd8, 4'd8, 4'd1, 4'd2, 4'd9, 4'd1};
    logic [14:0] expOuts  [14] = '{O_F_NRDY, O_F_NRDY, O_F_NRDY, O_F_RDY, O_DECODE,
                                   O_MADDR, O_MW_NRDY, O_MW_NRDY, O_MW_NRDY,
                                   O_MW_RDY, O_F_RDY, O_DECODE, O_BR_Z1, O_F_RDY};
    int doneCnt = 0;
    OpCode = SD;
    doReset();
    for (int i = 0; i < 14; i++) begin
      if (i == 10) OpCode = BEQ;
      tick(mrSeq[i], 1'b1);
      nChecks++;
      if (State !== expState[i] || outs !== expOuts[i]) begin
        nErrors++;
        $display("FAIL b2b[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                 i, State, outs, expState[i], expOuts[i]);
      end
      if (InstrDone) doneCnt++;
    end
    nChecks++;
    if (doneCnt !== 2) begin
      nErrors++;
      $display("FAIL b2b_done_count: got %0d expected 2", doneCnt);
    end
  endtask

  task automatic test_reset_mid_write;
    logic mrSeq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    OpCode = SD;
    doReset();
    for (int i = 0; i < 4; i++) tick(mrSeq[i], 1'b0);
    nChecks++;
    if (State !== 4'd8 || MemWrite !== 1'b1) begin
      nErrors++;
      $display("FAIL midwr_pre: state=%0d memwrite=%0b expected state=8 memwrite=1",
               State, MemWrite);
    end
    // Assert reset between edges: the write request must vanish at once.
    Reset = 1'b1;
    #1;
    nChecks++;
    if (State !== 4'd0 || MemWrite !== 1'b0 || outs !== O_ZERO) begin
      nErrors++;
      $display("FAIL midwr_async: state=%0d memwrite=%0b outs=%b expected 0 0 %b",
               State, MemWrite, outs, O_ZERO);
    end
    @(posedge Clk);
    #1;
    nChecks++;
    if (State !== 4'd0 || outs !== O_ZERO) begin
      nErrors++;
      $display("FAIL midwr_held: state=%0d outs=%b expected state=0 outs=%b",
               State, outs, O_ZERO);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    OpCode   = 7'd0;
    Zero     = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_ld_wait();
    test_sd();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_timeout();
    test_timeout_rescue();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #100000;
    nErrors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $fatal(1, "watchdog expired");
  end

endmodule
